fifo_frame_reader: RTL and testbench
====================================

FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 The block SHALL have parameter P_DATA_WIDTH, default 32, meaning FIFO/stream word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter P_LEN_WIDTH, default 11, meaning header byte-length field width.
REQ-003 The block SHALL have a single clock, clk_i; rst_ni is an asynchronous, active-low reset.
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 fifo_rd_o  out  1  read strobe to an upstream sync FIFO (non-FWFT).
REQ-007 fifo_data_i  in  P_DATA_WIDTH  FIFO read data, valid exactly one cycle after fifo_rd_o.
REQ-008 fifo_empty_i  in  1  FIFO empty flag.
REQ-009 tvalid_o  out  1  output word valid.
REQ-010 tready_i  in  1  downstream accept.
REQ-011 tdata_o  out  P_DATA_WIDTH  output word; byte lane 0 = bits [7:0].
REQ-012 tkeep_o  out  P_DATA_WIDTH/8  byte-valid mask.
REQ-013 tlast_o  out  1  final word of frame.
REQ-014 busy_o  out  1  high in any state other than IDLE.
REQ-015 frame_cnt_o  out  16  count of frames fully delivered (wraps 0xFFFF->0).
REQ-016 len_err_o  out  1  one-cycle pulse when a zero-length header is consumed.

Function
REQ-017 Frame format in FIFO: one header word, header[P_LEN_WIDTH-1:0] = byte length L, upper bits ignored; then ceil(L/B) payload words, B = P_DATA_WIDTH/8.
REQ-018 fifo_rd_o SHALL assert only when fifo_empty_i=0 and (output buffer occupancy + reads in flight) < 2.
REQ-019 FSM states: IDLE, HDR (header read issued, awaiting data), PAYLOAD.
REQ-020 IDLE->HDR when a header read is issued; HDR->PAYLOAD when L>0 (remaining-words counter loaded with ceil(L/B)); HDR->IDLE when L=0, with len_err_o pulsed in that cycle.
REQ-021 In PAYLOAD, reads SHALL stop once issued reads equal ceil(L/B); the header of the next frame SHALL NOT be read before the current frame's last payload read is issued.
REQ-022 PAYLOAD->IDLE on the cycle the tlast_o word is accepted (tvalid_o & tready_i); the next header read MAY be issued in that same cycle.
REQ-023 Output buffer SHALL be a 2-entry FIFO/skid; with tready_i held high and FIFO non-empty, throughput SHALL be one word per cycle after the 2-cycle header overhead.
REQ-024 tvalid_o, tdata_o, tkeep_o, tlast_o SHALL remain stable while tvalid_o=1 and tready_i=0.
REQ-025 tkeep_o SHALL be all ones except on the last word, where it has the low (L mod B) bits set, or all ones if L mod B = 0.
REQ-026 frame_cnt_o SHALL increment on acceptance of each tlast_o word.
REQ-027 Header words SHALL never appear on the output stream.

Reset
REQ-028 On rst_ni low, asynchronously: FSM=IDLE, buffer empty, in-flight cleared, fifo_rd_o=0, tvalid_o=0, tlast_o=0, tkeep_o=0, tdata_o=0, busy_o=0, frame_cnt_o=0, len_err_o=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; no output until a new header is read after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the header length field position/width constants.
REQ-031 The 2-entry output buffer SHALL be a sub-module named stream_skid_buffer.

Verification
REQ-032 B=4, FIFO holds header L=8 plus words A,B, tready_i=1 -> two output words A,B, tkeep=0xF both, tlast on B, frame_cnt_o=1.
REQ-033 L=5, words A,B -> B emitted with tkeep=0x1, tlast=1.
REQ-034 Header L=0 followed by header L=4, word C -> len_err_o single pulse; only C emitted, tkeep=0xF, tlast=1.
REQ-035 L=16, tready_i toggled 1,0,0,1... -> data stable during stalls, no word lost or duplicated, at most 2 reads outstanding.
REQ-036 Back-to-back frames L=4,L=4, tready_i=1 -> second header read issued in cycle first tlast accepted; frame_cnt_o=2.
REQ-037 rst_ni asserted after 1 of 4 payload words delivered -> all outputs zero immediately; after release and fresh header L=4, one word emitted with tlast=1.

Source files
------------

// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and header-field layout for the FIFO frame reader.
package fifo_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } frame_state_e;

    localparam int unsigned HDR_LEN_LSB   = 0;
    localparam int unsigned HDR_LEN_WIDTH = 11;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry output FIFO; the head entry drives the stream outputs directly.
module stream_skid_buffer #(
    parameter int unsigned P_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    input  logic [P_DATA_WIDTH-1:0]   in_data_i,
    input  logic [P_DATA_WIDTH/8-1:0] in_keep_i,
    input  logic                      in_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [P_DATA_WIDTH-1:0]   out_data_o,
    output logic [P_DATA_WIDTH/8-1:0] out_keep_o,
    output logic                      out_last_o,
    output logic [1:0]                count_o
);

    localparam int unsigned EW = P_DATA_WIDTH + P_DATA_WIDTH/8 + 1;

    logic [EW-1:0] e0_q, e1_q;
    logic [EW-1:0] in_entry;
    logic [1:0]    count_q;
    logic          pop, push;

    assign in_entry = {in_last_i, in_keep_i, in_data_i};
    assign pop      = (count_q != 2'd0) && out_ready_i;
    // A write into a full buffer is dropped unless the head leaves this cycle.
    assign push     = in_valid_i && ((count_q != 2'd2) || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= in_entry;
                    else                 e1_q <= in_entry;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_q <= in_entry;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = (count_q != 2'd0);
    assign {out_last_o, out_keep_o, out_data_o} = e0_q;
    assign count_o     = count_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Reads length-prefixed frames from a non-FWFT FIFO and emits them as a keep/last stream.
//   state      | meaning
//   ST_IDLE    | no frame active; issues a header read when room allows
//   ST_HDR     | header read issued, header data valid this cycle
//   ST_PAYLOAD | fetching payload words until the last one is accepted
module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_LEN_WIDTH  = HDR_LEN_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    output logic                      fifo_rd_o,
    input  logic [P_DATA_WIDTH-1:0]   fifo_data_i,
    input  logic                      fifo_empty_i,
    output logic                      tvalid_o,
    input  logic                      tready_i,
    output logic [P_DATA_WIDTH-1:0]   tdata_o,
    output logic [P_DATA_WIDTH/8-1:0] tkeep_o,
    output logic                      tlast_o,
    output logic                      busy_o,
    output logic [15:0]               frame_cnt_o,
    output logic                      len_err_o
);

    localparam int unsigned B  = P_DATA_WIDTH / 8;
    localparam int unsigned LW = P_LEN_WIDTH + 1;

    frame_state_e     state_q, state_d;
    logic             rd_q, run_q;
    logic [LW-1:0]    reads_left_q, reads_left_d;
    logic [LW-1:0]    words_left_q, words_left_d;
    logic [B-1:0]     last_keep_q, last_keep_d;
    logic [15:0]      frame_cnt_q;

    logic [P_LEN_WIDTH-1:0] hdr_len, hdr_rem;
    logic [LW-1:0]          hdr_words;
    logic [B-1:0]           hdr_keep;
    logic [1:0]             occ;
    logic [2:0]             load;
    logic                   pop, push, rd_ok, fifo_rd, len_err, frame_done;
    logic                   push_last;
    logic [B-1:0]           push_keep;

    assign hdr_len   = fifo_data_i[HDR_LEN_LSB +: P_LEN_WIDTH];
    assign hdr_words = ({1'b0, hdr_len} + LW'(B - 1)) / LW'(B);
    assign hdr_rem   = hdr_len % P_LEN_WIDTH'(B);

    always_comb begin
        hdr_keep = '0;
        for (int i = 0; i < B; i++) begin
            hdr_keep[i] = (hdr_rem == '0) || (P_LEN_WIDTH'(i) < hdr_rem);
        end
    end

    // Room counts the word leaving this cycle, which keeps one word per cycle flowing.
    assign pop   = tvalid_o && tready_i;
    assign load  = {1'b0, occ} + {2'b00, rd_q} - {2'b00, pop};
    assign rd_ok = run_q && !fifo_empty_i && (load < 3'd2);

    assign push      = rd_q && (state_q == ST_PAYLOAD);
    assign push_last = (words_left_q == LW'(1));
    assign push_keep = push_last ? last_keep_q : '1;

    always_comb begin
        state_d      = state_q;
        fifo_rd      = 1'b0;
        len_err      = 1'b0;
        frame_done   = 1'b0;
        reads_left_d = reads_left_q;
        words_left_d = push ? words_left_q - LW'(1) : words_left_q;
        last_keep_d  = last_keep_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_ok) begin
                    fifo_rd = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_len == '0) begin
                    len_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_PAYLOAD;
                    words_left_d = hdr_words;
                    last_keep_d  = hdr_keep;
                    reads_left_d = hdr_words;
                    if (rd_ok) begin
                        fifo_rd      = 1'b1;
                        reads_left_d = hdr_words - LW'(1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (pop && tlast_o) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                    if (rd_ok) begin
                        fifo_rd = 1'b1;
                        state_d = ST_HDR;
                    end
                end else if ((reads_left_q != '0) && rd_ok) begin
                    fifo_rd      = 1'b1;
                    reads_left_d = reads_left_q - LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rd_q         <= 1'b0;
            run_q        <= 1'b0;
            reads_left_q <= '0;
            words_left_q <= '0;
            last_keep_q  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= fifo_rd;
            run_q        <= 1'b1;
            reads_left_q <= reads_left_d;
            words_left_q <= words_left_d;
            last_keep_q  <= last_keep_d;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    stream_skid_buffer #(
        .P_DATA_WIDTH (P_DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (push),
        .in_data_i   (fifo_data_i),
        .in_keep_i   (push_keep),
        .in_last_i   (push_last),
        .out_valid_o (tvalid_o),
        .out_ready_i (tready_i),
        .out_data_o  (tdata_o),
        .out_keep_o  (tkeep_o),
        .out_last_o  (tlast_o),
        .count_o     (occ)
    );

    assign fifo_rd_o   = fifo_rd;
    assign len_err_o   = len_err;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader with a behavioural non-FWFT FIFO upstream.
module tb_fifo_frame_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fifo_rd_o;
    logic [31:0] fifo_data_i = '0;
    logic        fifo_empty_i;
    logic        tvalid_o;
    logic        tready_i = 1'b1;
    logic [31:0] tdata_o;
    logic [3:0]  tkeep_o;
    logic        tlast_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    logic        len_err_o;

    fifo_frame_reader #(
        .P_DATA_WIDTH (32),
        .P_LEN_WIDTH  (11)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .tvalid_o     (tvalid_o),
        .tready_i     (tready_i),
        .tdata_o      (tdata_o),
        .tkeep_o      (tkeep_o),
        .tlast_o      (tlast_o),
        .busy_o       (busy_o),
        .frame_cnt_o  (frame_cnt_o),
        .len_err_o    (len_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] mem [0:255];
    bit          is_hdr [0:255];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          pr_cnt = 0;
    bit          flush = 1'b0;
    exp_t        exp_q [$];
    bit          last_rd_q [$];
    int          acc_cnt = 0;
    int          len_err_cnt = 0;
    int          exp_frames = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          prev_stall = 1'b0;
    logic [37:0] prev_bus = '0;

    assign fifo_empty_i = (wr_idx == rd_idx);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Upstream FIFO: read data appears one cycle after the strobe.
    always @(posedge clk_i) begin
        if (flush) begin
            rd_idx <= wr_idx;
            pr_cnt <= 0;
        end else if (fifo_rd_o) begin
            fifo_data_i <= mem[rd_idx[7:0]];
            rd_idx      <= rd_idx + 1;
            if (!is_hdr[rd_idx[7:0]]) pr_cnt <= pr_cnt + 1;
        end
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (flush) begin
            acc_cnt    = 0;
            prev_stall = 1'b0;
        end else if (rst_ni) begin
            if (prev_stall)
                chk("stall_stable", {tvalid_o, tlast_o, tkeep_o, tdata_o}, prev_bus);
            if (fifo_rd_o) begin
                chk("rd_nonempty", fifo_empty_i, 0);
                if (!is_hdr[rd_idx[7:0]])
                    chk("outstanding_le2",
                        (pr_cnt + 1 - acc_cnt - int'(tvalid_o && tready_i)) <= 2, 1);
            end
            if (len_err_o) len_err_cnt++;
            if (tvalid_o && tready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", tdata_o, 0);
                    chk("unexpected_word_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata_o, e.data);
                    chk("tkeep", tkeep_o, e.keep);
                    chk("tlast", tlast_o, e.last);
                end
                if (tlast_o) last_rd_q.push_back(fifo_rd_o);
                acc_cnt++;
            end
            prev_stall = tvalid_o && !tready_i;
            prev_bus   = {tvalid_o, tlast_o, tkeep_o, tdata_o};
        end
    end

    task automatic push_word(input logic [31:0] w, input bit hdr);
        mem[wr_idx[7:0]]    = w;
        is_hdr[wr_idx[7:0]] = hdr;
        wr_idx++;
    endtask

    task automatic push_frame(input int len, input logic [31:0] hdr_hi);
        int          nw;
        logic [31:0] d;
        logic [3:0]  k;
        nw = (len + 3) / 4;
        push_word(hdr_hi | 32'(len), 1'b1);
        for (int i = 0; i < nw; i++) begin
            d = $urandom;
            k = 4'hF;
            if (i == nw - 1 && (len % 4) != 0) k = 4'((1 << (len % 4)) - 1);
            push_word(d, 1'b0);
            exp_q.push_back('{data: d, keep: k, last: (i == nw - 1)});
        end
        if (len > 0) exp_frames++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        int k;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (!(exp_q.size() == 0 && !busy_o && fifo_empty_i) && k < max);
        if (k >= max) chk({tag, "_timeout"}, exp_q.size(), 0);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fifo_rd"}, fifo_rd_o, 0);
        chk({tag, "_tvalid"}, tvalid_o, 0);
        chk({tag, "_tlast"}, tlast_o, 0);
        chk({tag, "_tkeep"}, tkeep_o, 0);
        chk({tag, "_tdata"}, tdata_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_frame_cnt"}, frame_cnt_o, 0);
        chk({tag, "_len_err"}, len_err_o, 0);
    endtask

    initial begin
        int k, base;

        // Frame waiting in the FIFO while reset is held: nothing may be read.
        push_frame(8, 32'h0);
        cyc(3);
        chk_all_zero("reset");
        rst_ni = 1'b1;
        drain("l8", 100);
        chk("frame_cnt_l8", frame_cnt_o, exp_frames);

        push_frame(5, 32'hFFFF_F800);
        drain("l5", 100);
        chk("frame_cnt_l5", frame_cnt_o, exp_frames);

        len_err_cnt = 0;
        push_frame(0, 32'h0);
        push_frame(4, 32'h0);
        drain("l0", 100);
        chk("len_err_pulses", len_err_cnt, 1);
        chk("frame_cnt_l0", frame_cnt_o, exp_frames);

        push_frame(16, 32'h0);
        k = 0;
        while (!(exp_q.size() == 0 && !busy_o && fifo_empty_i) && k < 300) begin
            @(posedge clk_i);
            #1;
            tready_i = (k % 4 == 0) || (k % 4 == 3);
            k++;
        end
        if (k >= 300) chk("stall_timeout", exp_q.size(), 0);
        tready_i = 1'b1;
        cyc(2);
        chk("frame_cnt_l16", frame_cnt_o, exp_frames);

        last_rd_q.delete();
        push_frame(4, 32'h0);
        push_frame(4, 32'h0);
        drain("b2b", 100);
        chk("b2b_tlast_count", last_rd_q.size(), 2);
        if (last_rd_q.size() > 0) chk("b2b_hdr_rd_at_tlast", last_rd_q[0], 1);
        chk("frame_cnt_b2b", frame_cnt_o, exp_frames);

        base = acc_cnt;
        push_frame(16, 32'h0);
        k = 0;
        while (acc_cnt - base < 1 && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 100) chk("midreset_timeout", acc_cnt - base, 1);
        @(posedge clk_i);
        #2;
        flush  = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("midreset");
        cyc(2);
        flush = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        rst_ni = 1'b1;
        cyc(5);
        chk("post_reset_idle_tvalid", tvalid_o, 0);
        chk("post_reset_idle_busy", busy_o, 0);
        push_frame(4, 32'h0);
        drain("post_reset", 100);
        chk("frame_cnt_post_reset", frame_cnt_o, exp_frames);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
